// File: rtl/mdr_handshake_if.sv
// Control/status handshake bundle between the CPU sequencer/memory and mdr_handshake.
// Parity pins (mem_par, par_err) exist only when MDR_PARITY_EN is defined.
interface mdr_handshake_if;
    logic R_W;
    logic in_bus_en;
    logic out_bus_en;
    logic start;
    logic mem_ack;
    logic mem_req;
    logic mem_we;
    logic busy;
    logic done;
    logic err;
`ifdef MDR_PARITY_EN
    logic mem_par;
    logic par_err;

    modport master (
        output R_W, in_bus_en, out_bus_en, start, mem_ack, mem_par,
        input  mem_req, mem_we, busy, done, err, par_err
    );
    modport slave (
        input  R_W, in_bus_en, out_bus_en, start, mem_ack, mem_par,
        output mem_req, mem_we, busy, done, err, par_err
    );
`else
    modport master (
        output R_W, in_bus_en, out_bus_en, start, mem_ack,
        input  mem_req, mem_we, busy, done, err
    );
    modport slave (
        input  R_W, in_bus_en, out_bus_en, start, mem_ack,
        output mem_req, mem_we, busy, done, err
    );
`endif
endinterface

// File: rtl/mdr_handshake.sv
// Memory data register with req/ack memory handshake, wait states and timeout abort.
// Define MDR_PARITY_EN to add even-parity checking of read data (mem_par in, par_err out).
module mdr_handshake #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    mdr_handshake_if.slave    hs,
    inout  wire [DATA_W-1:0]  data_bus,
    inout  wire [DATA_W-1:0]  data_mem
);
    // Counter only needs to reach TIMEOUT-1; the abort fires on that count.
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  mdr_q, mdr_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               mem_req_q, mem_we_q, busy_q;
`ifdef MDR_PARITY_EN
    logic               par_err_q, par_err_d;
`endif

    // Next-state, register and status logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mdr_d   = mdr_q;
        done_d  = 1'b0;
        err_d   = err_q;
`ifdef MDR_PARITY_EN
        par_err_d = par_err_q;
`endif
        case (state_q)
            IDLE: begin
                // A same-cycle load is visible to a WR started in this cycle.
                if (hs.in_bus_en) begin
                    mdr_d = data_bus;
                end
                if (hs.start) begin
                    state_d = hs.R_W ? RD : WR;
                    cnt_d   = '0;
                    err_d   = 1'b0;
`ifdef MDR_PARITY_EN
                    par_err_d = 1'b0;
`endif
                end
            end
            RD, WR: begin
                if (hs.mem_ack) begin
                    if (state_q == RD) begin
                        mdr_d = data_mem;
`ifdef MDR_PARITY_EN
                        par_err_d = ((^data_mem) != hs.mem_par);
`endif
                    end
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; handshake outputs follow the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mdr_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            busy_q    <= 1'b0;
`ifdef MDR_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mdr_q     <= mdr_d;
            done_q    <= done_d;
            err_q     <= err_d;
            mem_req_q <= (state_d != IDLE);
            mem_we_q  <= (state_d == WR);
            busy_q    <= (state_d != IDLE);
`ifdef MDR_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    assign hs.mem_req = mem_req_q;
    assign hs.mem_we  = mem_we_q;
    assign hs.busy    = busy_q;
    assign hs.done    = done_q;
    assign hs.err     = err_q;
`ifdef MDR_PARITY_EN
    assign hs.par_err = par_err_q;
`endif

    // The memory side is only driven while a write is in flight.
    assign data_mem = (state_q == WR) ? mdr_q : {DATA_W{1'bz}};
    assign data_bus = hs.out_bus_en   ? mdr_q : {DATA_W{1'bz}};
endmodule

// File: tb/tb_mdr_handshake.sv
// Directed bench for mdr_handshake: reset, zero-wait read, wait-state write, timeout, collisions.
// Parity vectors run only when MDR_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_mdr_handshake;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] bus_drv, mem_drv;
    logic              bus_oe, mem_oe;
    wire  [DATA_W-1:0] data_bus;
    wire  [DATA_W-1:0] data_mem;
    int                vectors = 0;
    int                miscompares = 0;

    mdr_handshake_if hs();

    assign data_bus = bus_oe ? bus_drv : {DATA_W{1'bz}};
    assign data_mem = mem_oe ? mem_drv : {DATA_W{1'bz}};

    mdr_handshake #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .reset    (reset),
        .hs       (hs),
        .data_bus (data_bus),
        .data_mem (data_mem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {mem_req, mem_we, busy, done, err}
    function automatic logic [31:0] outs();
        return 32'({hs.mem_req, hs.mem_we, hs.busy, hs.done, hs.err});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; hs.start = 1'b1; hs.R_W = 1'b1;
        hs.in_bus_en = 1'b0; hs.out_bus_en = 1'b0; hs.mem_ack = 1'b0;
        bus_oe = 1'b0; mem_oe = 1'b0; bus_drv = '0; mem_drv = '0;
`ifdef MDR_PARITY_EN
        hs.mem_par = 1'b0;
`endif
        // Reset with start held high
        tick();
        chk("rst_outs", outs(), 32'b00000);
        reset = 1'b0; hs.start = 1'b0;
        bus_oe = 1'b1; bus_drv = 16'h5A5A; mem_oe = 1'b1; mem_drv = 16'h3C3C; #1;
        chk("rst_bus_rel", 32'(data_bus), 32'h5A5A);
        chk("rst_mem_rel", 32'(data_mem), 32'h3C3C);
        bus_oe = 1'b0; mem_oe = 1'b0; hs.out_bus_en = 1'b1; #1;
        chk("rst_reg", 32'(data_bus), 32'h0000);
        hs.out_bus_en = 1'b0;
        tick();
        chk("rst_idle", outs(), 32'b00000);

        // Zero-wait read of FFFF
        hs.mem_ack = 1'b1; mem_oe = 1'b1; mem_drv = 16'hFFFF;
        hs.start = 1'b1; hs.R_W = 1'b1;
        tick();
        hs.start = 1'b0;
        chk("rd0_req", outs(), 32'b10100);
        tick();
        chk("rd0_done", outs(), 32'b00010);
        mem_oe = 1'b0; hs.mem_ack = 1'b0; hs.out_bus_en = 1'b1; #1;
        chk("rd0_data", 32'(data_bus), 32'hFFFF);
        hs.out_bus_en = 1'b0;
        tick();
        chk("rd0_pulse", outs(), 32'b00000);

        // Load + write in one cycle, three wait states
        bus_oe = 1'b1; bus_drv = 16'hA5C3; hs.in_bus_en = 1'b1;
        hs.start = 1'b1; hs.R_W = 1'b0;
        tick();
        bus_oe = 1'b0; hs.in_bus_en = 1'b0; hs.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("wr_wait_outs", outs(), 32'b11100);
            chk("wr_wait_mem", 32'(data_mem), 32'hA5C3);
            tick();
        end
        hs.mem_ack = 1'b1;
        chk("wr_ack_outs", outs(), 32'b11100);
        chk("wr_ack_mem", 32'(data_mem), 32'hA5C3);
        tick();
        hs.mem_ack = 1'b0;
        chk("wr_done", outs(), 32'b00010);
        mem_oe = 1'b1; mem_drv = 16'h5A3C; #1;
        chk("wr_mem_rel", 32'(data_mem), 32'h5A3C);
        mem_oe = 1'b0;

        // Timeout on a read; register must keep A5C3
        mem_oe = 1'b1; mem_drv = 16'h1234;
        hs.start = 1'b1; hs.R_W = 1'b1;
        tick();
        hs.start = 1'b0;
        for (int i = 1; i < int'(TIMEOUT); i++) begin
            chk("to_wait", outs(), 32'b10100);
            tick();
        end
        chk("to_last", outs(), 32'b10100);
        tick();
        chk("to_done", outs(), 32'b00011);
        mem_oe = 1'b0; hs.out_bus_en = 1'b1; #1;
        chk("to_reg", 32'(data_bus), 32'hA5C3);
        hs.out_bus_en = 1'b0;
        tick();
        chk("to_sticky", outs(), 32'b00001);
        hs.mem_ack = 1'b1;
        tick();
        chk("idle_ack", outs(), 32'b00001);
        hs.mem_ack = 1'b0;

        // Next start clears err; ack on the last allowed cycle wins
        mem_oe = 1'b1; mem_drv = 16'h0F0F;
        hs.start = 1'b1; hs.R_W = 1'b1;
        tick();
        hs.start = 1'b0;
        chk("err_clr", outs(), 32'b10100);
        for (int i = 1; i < int'(TIMEOUT); i++) tick();
        hs.mem_ack = 1'b1;
        tick();
        hs.mem_ack = 1'b0;
        chk("ack_wins", outs(), 32'b00010);
        mem_oe = 1'b0; hs.out_bus_en = 1'b1; #1;
        chk("ack_wins_reg", 32'(data_bus), 32'h0F0F);
        hs.out_bus_en = 1'b0;

        // Start and in_bus_en while busy are ignored
        mem_oe = 1'b1; mem_drv = 16'h2222;
        hs.start = 1'b1; hs.R_W = 1'b1;
        tick();
        hs.R_W = 1'b0; hs.in_bus_en = 1'b1; bus_oe = 1'b1; bus_drv = 16'h1111;
        tick();
        hs.start = 1'b0; hs.in_bus_en = 1'b0; bus_oe = 1'b0;
        chk("busy_start", outs(), 32'b10100);
        hs.mem_ack = 1'b1;
        tick();
        hs.mem_ack = 1'b0;
        chk("busy_rd_done", outs(), 32'b00010);
        mem_oe = 1'b0;
        tick();
        chk("no_queue", outs(), 32'b00000);
        hs.out_bus_en = 1'b1; #1;
        chk("busy_rd_reg", 32'(data_bus), 32'h2222);
        hs.out_bus_en = 1'b0;

        // in_bus_en during WR, then reset mid-transaction
        hs.start = 1'b1; hs.R_W = 1'b0;
        tick();
        hs.start = 1'b0; hs.in_bus_en = 1'b1; bus_oe = 1'b1; bus_drv = 16'h1111;
        tick();
        hs.in_bus_en = 1'b0; bus_oe = 1'b0;
        chk("wr_hold_mem", 32'(data_mem), 32'h2222);
        chk("wr_hold_outs", outs(), 32'b11100);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid", outs(), 32'b00000);
        mem_oe = 1'b1; mem_drv = 16'h5555; #1;
        chk("rst_mid_mem", 32'(data_mem), 32'h5555);
        mem_oe = 1'b0;
        tick();
        chk("rst_no_done", outs(), 32'b00000);

`ifdef MDR_PARITY_EN
        // Parity: 0001 has odd weight, 0003 even
        hs.mem_ack = 1'b1; mem_oe = 1'b1; mem_drv = 16'h0001; hs.mem_par = 1'b0;
        hs.start = 1'b1; hs.R_W = 1'b1;
        tick();
        hs.start = 1'b0;
        tick();
        chk("par_done", outs(), 32'b00010);
        chk("par_err_1", 32'(hs.par_err), 32'h1);
        mem_drv = 16'h0003;
        hs.start = 1'b1;
        tick();
        hs.start = 1'b0;
        tick();
        chk("par_err_0", 32'(hs.par_err), 32'h0);
        hs.mem_ack = 1'b0; mem_oe = 1'b0;
        hs.out_bus_en = 1'b1; #1;
        chk("par_reg", 32'(data_bus), 32'h0003);
        hs.out_bus_en = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
